// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: synchronised, debounced switches and buttons, LED register with
// atomic set/clear, sticky button-press flags and a maskable interrupt.

module mmio_gpio_debounce #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] stable
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2;
  logic [CW-1:0]    cnt [WIDTH];

  // NOTE: non-blocking assignments keep the synchroniser a true two-stage pipeline;
  // blocking would collapse sync1/sync2 into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
endmodule

module mmio_gpio #(
  parameter int SW_WIDTH        = 16,
  parameter int BTN_WIDTH       = 5,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          io_address,
  input  logic [31:0]          io_write_value,
  input  logic                 io_write_en,
  input  logic                 io_read_en,
  output logic [31:0]          io_read_value,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 irq
);
  typedef enum logic [2:0] {
    REG_SW      = 3'd0,
    REG_BTN     = 3'd1,
    REG_LED     = 3'd2,
    REG_LED_SET = 3'd3,
    REG_LED_CLR = 3'd4,
    REG_PEND    = 3'd5,
    REG_IE      = 3'd6,
    REG_NONE    = 3'd7
  } reg_sel_e;

  reg_sel_e             sel;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic [BTN_WIDTH-1:0] btn_stable, btn_prev, pend, ie, pend_clr;
  logic [LED_WIDTH-1:0] wdata_led;
  logic [BTN_WIDTH-1:0] wdata_btn;
  logic [31:0]          rdata;
  logic                 unused_bits;

  assign sel         = reg_sel_e'(io_address[4:2]);
  assign wdata_led   = io_write_value[LED_WIDTH-1:0];
  assign wdata_btn   = io_write_value[BTN_WIDTH-1:0];
  assign unused_bits = ^{io_address[31:5], io_address[1:0], io_write_value};

  mmio_gpio_debounce #(.WIDTH(SW_WIDTH), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .rst(rst), .pin(sw_in), .stable(sw_stable)
  );

  mmio_gpio_debounce #(.WIDTH(BTN_WIDTH), .CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk(clk), .rst(rst), .pin(btn_in), .stable(btn_stable)
  );

  assign pend_clr = (io_write_en && sel == REG_PEND) ? wdata_btn : '0;
  assign irq      = |(pend & ie);

  always_comb begin
    rdata = '0;
    case (sel)
      REG_SW:   rdata = 32'(sw_stable);
      REG_BTN:  rdata = 32'(btn_stable);
      REG_LED:  rdata = 32'(led_out);
      REG_PEND: rdata = 32'(pend);
      REG_IE:   rdata = 32'(ie);
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_read_value <= '0;
      led_out       <= '0;
      pend          <= '0;
      ie            <= '0;
      btn_prev      <= '0;
    end else begin
      btn_prev <= btn_stable;
      // A fresh rising edge is ORed in after the clear, so a simultaneous set wins.
      pend     <= (pend & ~pend_clr) | (btn_stable & ~btn_prev);
      if (io_write_en) begin
        case (sel)
          REG_LED:     led_out <= wdata_led;
          REG_LED_SET: led_out <= led_out | wdata_led;
          REG_LED_CLR: led_out <= led_out & ~wdata_led;
          REG_IE:      ie      <= wdata_btn;
          default:     ;
        endcase
      end
      if (io_read_en) io_read_value <= rdata;
    end
  end
endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with DEBOUNCE_CYCLES=4 and default widths.

module tb_mmio_gpio;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_address, io_write_value, io_read_value;
  logic        io_write_en, io_read_en;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic [15:0] led_out;
  logic        irq;

  int passed = 0;
  int total  = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  mmio_gpio #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .io_read_value(io_read_value),
    .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out), .irq(irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    io_address = addr; io_write_value = data; io_write_en = 1'b1;
    tick(1);
    io_write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    io_address = addr; io_read_en = 1'b1;
    tick(1);
    io_read_en = 1'b0;
    data = io_read_value;
  endtask

  task automatic test_reset;
    rst = 1'b1; sw_in = 16'hFFFF; btn_in = '0;
    io_address = 32'h08; io_write_value = 32'hFFFF; io_write_en = 1'b1; io_read_en = 1'b0;
    tick(2);
    total++; if (led_out !== 16'h0) $display("FAIL reset_led: got %h expected 0000", led_out); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else passed++;
    total++; if (io_read_value !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", io_read_value); else passed++;
    rst = 1'b0; io_write_en = 1'b0;
    bus_read(32'h00, rd);
    total++; if (rd !== 32'h0) $display("FAIL reset_sw_read: got %h expected 0", rd); else passed++;
    sw_in = '0;
    tick(10);
  endtask

  task automatic test_led;
    bus_write(32'h08, 32'h0000_00F0);
    total++; if (led_out !== 16'h00F0) $display("FAIL led_write: got %h expected 00f0", led_out); else passed++;
    bus_write(32'h0C, 32'h0000_0F00);
    total++; if (led_out !== 16'h0FF0) $display("FAIL led_set: got %h expected 0ff0", led_out); else passed++;
    bus_write(32'h10, 32'h0000_0030);
    total++; if (led_out !== 16'h0FC0) $display("FAIL led_clr: got %h expected 0fc0", led_out); else passed++;
    bus_read(32'h08, rd);
    total++; if (rd !== 32'h0000_0FC0) $display("FAIL led_read: got %h expected 00000fc0", rd); else passed++;
    bus_read(32'h0C, rd);
    total++; if (rd !== 32'h0) $display("FAIL led_set_read: got %h expected 0", rd); else passed++;
    bus_read(32'h10, rd);
    total++; if (rd !== 32'h0) $display("FAIL led_clr_read: got %h expected 0", rd); else passed++;
    bus_read(32'hFFFF_FF2B, rd);
    total++; if (rd !== 32'h0000_0FC0) $display("FAIL led_alias_read: got %h expected 00000fc0", rd); else passed++;
    tick(2);
    total++; if (io_read_value !== 32'h0000_0FC0) $display("FAIL read_hold: got %h expected 00000fc0", io_read_value); else passed++;
  endtask

  task automatic test_debounce;
    logic [31:0] exp;
    sw_in = 16'h0001;
    for (int k = 0; k <= 6; k++) begin
      bus_read(32'h00, rd);
      exp = (k >= 6) ? 32'h1 : 32'h0;
      total++; if (rd !== exp) $display("FAIL sw_latency_cycle%0d: got %h expected %h", k, rd, exp); else passed++;
    end
    btn_in = 5'h01;
    tick(3);
    btn_in = 5'h00;
    tick(8);
    bus_read(32'h04, rd);
    total++; if (rd !== 32'h0) $display("FAIL btn_glitch: got %h expected 0", rd); else passed++;
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h0) $display("FAIL glitch_pend: got %h expected 0", rd); else passed++;
  endtask

  task automatic test_pending_irq;
    bus_write(32'h18, 32'h0000_0001);
    total++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq); else passed++;
    btn_in = 5'h01;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (k == 5) begin
        total++; if (irq !== 1'b0) $display("FAIL irq_early: got %b expected 0", irq); else passed++;
      end
      if (k == 6) begin
        total++; if (irq !== 1'b1) $display("FAIL irq_on_time: got %b expected 1", irq); else passed++;
      end
    end
    bus_read(32'h04, rd);
    total++; if (rd !== 32'h1) $display("FAIL btn_stable: got %h expected 1", rd); else passed++;
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h1) $display("FAIL pend_set: got %h expected 1", rd); else passed++;
    bus_write(32'h18, 32'h0);
    total++; if (irq !== 1'b0) $display("FAIL irq_masked: got %b expected 0", irq); else passed++;
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h1) $display("FAIL ie_keeps_pend: got %h expected 1", rd); else passed++;
    bus_write(32'h18, 32'h1);
    total++; if (irq !== 1'b1) $display("FAIL irq_unmasked: got %b expected 1", irq); else passed++;
    bus_write(32'h14, 32'h1);
    total++; if (irq !== 1'b0) $display("FAIL irq_w1c: got %b expected 0", irq); else passed++;
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h0) $display("FAIL pend_w1c: got %h expected 0", rd); else passed++;
    btn_in = 5'h00;
    tick(10);
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h0) $display("FAIL release_pend: got %h expected 0", rd); else passed++;
    bus_read(32'h04, rd);
    total++; if (rd !== 32'h0) $display("FAIL btn_released: got %h expected 0", rd); else passed++;
  endtask

  task automatic test_collision;
    btn_in = 5'h04;
    tick(6);
    bus_write(32'h14, 32'h4);
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h4) $display("FAIL set_beats_clear: got %h expected 4", rd); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL irq_bit2_disabled: got %b expected 0", irq); else passed++;
    bus_write(32'h14, 32'h4);
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h0) $display("FAIL late_w1c: got %h expected 0", rd); else passed++;
    btn_in = 5'h00;
    tick(10);
  endtask

  task automatic test_unmapped_trunc;
    bus_write(32'h1C, 32'hFFFF_FFFF);
    total++; if (led_out !== 16'h0FC0) $display("FAIL unmapped_led: got %h expected 0fc0", led_out); else passed++;
    bus_read(32'h18, rd);
    total++; if (rd !== 32'h1) $display("FAIL unmapped_ie: got %h expected 1", rd); else passed++;
    bus_read(32'h14, rd);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_pend: got %h expected 0", rd); else passed++;
    bus_read(32'h1C, rd);
    total++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h expected 0", rd); else passed++;
    bus_write(32'h08, 32'hABCD_1234);
    bus_read(32'h08, rd);
    total++; if (rd !== 32'h0000_1234) $display("FAIL led_trunc: got %h expected 00001234", rd); else passed++;
  endtask

  task automatic test_back_to_back;
    io_address = 32'h08; io_write_value = 32'h5555; io_write_en = 1'b1; io_read_en = 1'b1;
    tick(1);
    io_write_en = 1'b0; io_read_en = 1'b0;
    total++; if (io_read_value !== 32'h0000_1234) $display("FAIL rmw_old_value: got %h expected 00001234", io_read_value); else passed++;
    total++; if (led_out !== 16'h5555) $display("FAIL rmw_new_led: got %h expected 5555", led_out); else passed++;
  endtask

  initial begin
    io_address = '0; io_write_value = '0; io_write_en = 1'b0; io_read_en = 1'b0;
    sw_in = '0; btn_in = '0; rst = 1'b1;
    #1;
    test_reset;
    test_led;
    test_debounce;
    test_pending_irq;
    test_collision;
    test_unmapped_trunc;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised memory-mapped GPIO peripheral for the Risc32 I/O port. Replaces ad-hoc switch/button/LED glue with synchronised, debounced inputs, an LED output register with atomic set/clear, sticky button-press flags and a maskable interrupt. It sits between the core's `io_*` bus and the board pins; base-address decode is done outside the block.

## Interface
- `SW_WIDTH`, default 16: number of switch inputs; 1..32.
- `BTN_WIDTH`, default 5: number of button inputs; 1..32.
- `LED_WIDTH`, default 16: number of LED outputs; 1..32.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept an input change; ≥1.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `io_address`  in  32: byte address; only `[4:2]` decoded.
- `io_write_value`  in  32: write data.
- `io_write_en`  in  1: write strobe, one register write per cycle.
- `io_read_en`  in  1: read strobe.
- `io_read_value`  out  32: registered read data.
- `sw_in`  in  SW_WIDTH: raw asynchronous switch pins.
- `btn_in`  in  BTN_WIDTH: raw asynchronous button pins.
- `led_out`  out  LED_WIDTH: LED register contents.
- `irq`  out  1: `|(BTN_PEND & BTN_IE)`.

## Operation
- Register map, selected by `io_address[4:2]`:
  - 0 `SW`, RO: debounced switches, zero-extended.
  - 1 `BTN`, RO: debounced buttons, zero-extended.
  - 2 `LED`, RW: write replaces the LED register; read returns it.
  - 3 `LED_SET`, WO: LED |= wdata. Reads as 0.
  - 4 `LED_CLR`, WO: LED &= ~wdata. Reads as 0.
  - 5 `BTN_PEND`, RW1C: bit set on a debounced rising edge of a button; writing 1 clears the bit.
  - 6 `BTN_IE`, RW: per-button interrupt enable.
  - 7: unmapped. Reads return 0; writes are ignored.
- Write data is truncated to the register width. Unused read bits are 0. `io_address[1:0]`, bits above 4, and any data-size signal are ignored; every access is a full word.
- Input path, per bit: 2-FF synchroniser, then a debounce counter.
  - If the synchronised value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, the stable value takes the synchronised value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never reaches the stable value.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It never wraps, because it clears on acceptance.
- Pending: a `BTN_PEND` bit sets when the stable button bit goes 0→1. If a set and a W1C of the same bit land in the same cycle, the set wins.
- A 1→0 button edge never sets pending.
- Writing `BTN_IE` does not alter pending bits.

## Timing
- Reset values: `io_read_value`, `led_out`, `BTN_PEND` and `BTN_IE` are 0. Synchroniser flops, stable values and counters are 0. `irq` is 0.
- Reset asserted mid-debounce discards the count. Reset has priority over a simultaneous write.
- Read latency is 1 cycle. `io_read_value` loads the selected register on the edge where `io_read_en`=1 and holds otherwise.
- Read-modify-write sees pre-write state: a read and a write in the same cycle return the old value.
- Writes take effect on the edge where `io_write_en`=1. `led_out` shows the new value the next cycle.
- Input latency: a pin change held steady appears in `SW`/`BTN` exactly 2 + `DEBOUNCE_CYCLES` cycles after it is first sampled.
- The pending bit sets 1 cycle after the stable value rises.
- `irq` is combinational from registered `BTN_PEND`/`BTN_IE`, so it rises in the same cycle the pending bit is visible.

## Test plan
Parameters for all tests: `DEBOUNCE_CYCLES`=4, default widths.
- Reset: hold `rst` 2 cycles with `sw_in`=0xFFFF → `led_out`=0, `irq`=0; reading addr 0x00 next cycle returns 0.
- LED atomics: write `LED`=0x00F0, `LED_SET`=0x0F00, `LED_CLR`=0x0030 → `led_out`=0x0FC0; reading 0x08 returns 0x00000FC0; reading 0x0C and 0x10 returns 0.
- Debounce: `sw_in`=0x0001 steady → `SW` reads 0 through cycle 5 and reads 1 from cycle 6. Pulsing `btn_in[0]` high for 3 cycles → `BTN` stays 0 and no pending bit sets.
- Pending/IRQ: `BTN_IE`=0x01, hold `btn_in[0]` 10 cycles → `BTN_PEND`=0x01 and `irq`=1. Writing `BTN_PEND`=0x01 → both clear. A release edge sets nothing.
- Set-vs-clear collision: a W1C of bit 2 in the same cycle as the debounced rise of `btn_in[2]` → `BTN_PEND[2]`=1.
- Unmapped/truncation: write 0xFFFFFFFF to 0x1C → no state change. Write 0xABCD1234 to `LED` → reads back 0x00001234.
